// File: rtl/led_blink_pkg.sv
// Shared constants for the multi-channel LED controller: mode encodings,
// CTRL field offsets and the STATUS word position.
package led_blink_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_PULSE = 2'd3;

   localparam int MODE_LSB = 0;
   localparam int HP_LSB   = 8;

   // STATUS sits directly after the last CTRL word.
   function automatic int status_index(input int channels);
      return channels;
   endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: holds mode, half-period and tick counter, and produces
// the LED level for OFF / ON / BLINK / PULSE operation.
module led_blink_channel
   import led_blink_pkg::*;
#(
   parameter int PERIOD_BITS = 8
)
(
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   tick,
   input  logic                   wr_mode,
   input  logic                   wr_hp,
   input  logic [1:0]             mode_in,
   input  logic [PERIOD_BITS-1:0] hp_in,
   output logic                   led,
   output logic [1:0]             mode,
   output logic [PERIOD_BITS-1:0] hp
);

   logic                   r_led;
   logic [1:0]             r_mode;
   logic [PERIOD_BITS-1:0] r_hp;
   logic [PERIOD_BITS-1:0] r_cnt;

   logic [PERIOD_BITS-1:0] w_ehp_m1;
   logic                   w_fire;

   // HP of 0 behaves as 1; >= lets a shortened HP fire on the very next tick.
   assign w_ehp_m1 = (r_hp == '0) ? '0 : r_hp - PERIOD_BITS'(1);
   assign w_fire   = (r_cnt >= w_ehp_m1);

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_led  <= 1'b0;
         r_mode <= MODE_OFF;
         r_hp   <= '0;
         r_cnt  <= '0;
      end else begin
         if (wr_hp) begin
            r_hp <= hp_in;
         end
         if (wr_mode) begin
            r_mode <= mode_in;
            r_cnt  <= '0;
            r_led  <= (mode_in != MODE_OFF);
         end else if (tick && !wr_hp) begin
            case (r_mode)
               MODE_BLINK: begin
                  if (w_fire) begin
                     r_led <= ~r_led;
                     r_cnt <= '0;
                  end else begin
                     r_cnt <= r_cnt + PERIOD_BITS'(1);
                  end
               end
               MODE_PULSE: begin
                  if (w_fire) begin
                     r_led  <= 1'b0;
                     r_mode <= MODE_OFF;
                     r_cnt  <= '0;
                  end else begin
                     r_cnt <= r_cnt + PERIOD_BITS'(1);
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign led  = r_led;
   assign mode = r_mode;
   assign hp   = r_hp;

endmodule

// File: rtl/led_blink_ctrl.sv
// Memory-mapped LED controller: shared prescaler, native-bus handshake,
// register decode and readback mux over a row of LED channels.
module led_blink_ctrl
   import led_blink_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int PRESCALE    = 50000,
   parameter int PERIOD_BITS = 8,
   parameter int ADDR_BITS   = 4
)
(
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 mem_valid,
   input  logic [ADDR_BITS-1:0] mem_addr,
   input  logic [31:0]          mem_wdata,
   input  logic [3:0]           mem_wstrb,
   output logic                 mem_ready,
   output logic [31:0]          mem_rdata,
   output logic [CHANNELS-1:0]  led
);

   localparam int PRE_BITS   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int HP_BYTES   = (PERIOD_BITS + 7) / 8;
   localparam int STATUS_IDX = status_index(CHANNELS);

   logic [PRE_BITS-1:0] r_pre;
   logic                r_ready;
   logic [31:0]         r_rdata;

   logic                w_tick;
   logic                w_req;
   logic                w_write;
   logic                w_hp_strb;
   logic [31:0]         w_rd;
   logic                w_unused;

   logic [CHANNELS-1:0]    w_led;
   logic [1:0]             w_mode  [CHANNELS];
   logic [PERIOD_BITS-1:0] w_hp    [CHANNELS];
   logic [PERIOD_BITS-1:0] w_hp_in [CHANNELS];
   logic [31:0]            w_ctrl  [CHANNELS];
   logic [CHANNELS-1:0]    w_sel;

   assign w_tick    = (r_pre == PRE_BITS'(PRESCALE - 1));
   // Ready is forced low for a cycle after each pulse, so a held request is served once.
   assign w_req     = mem_valid && !r_ready;
   assign w_write   = w_req && (mem_wstrb != 4'b0000);
   assign w_hp_strb = |mem_wstrb[HP_BYTES:1];
   assign w_unused  = ^{mem_wdata, mem_wstrb};

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         assign w_sel[gi] = w_write && (mem_addr == ADDR_BITS'(gi));

         // Bytes without a strobe keep the channel's current HP bits.
         for (genvar gk = 0; gk < PERIOD_BITS; gk++) begin : g_hp_bit
            assign w_hp_in[gi][gk] = mem_wstrb[(HP_LSB + gk) / 8] ?
                                     mem_wdata[HP_LSB + gk] : w_hp[gi][gk];
         end

         assign w_ctrl[gi] = (32'(w_mode[gi]) << MODE_LSB) |
                             (32'(w_hp[gi]) << HP_LSB);

         led_blink_channel #(
            .PERIOD_BITS (PERIOD_BITS)
         ) u_channel (
            .clk     (clk),
            .nreset  (nreset),
            .tick    (w_tick),
            .wr_mode (w_sel[gi] && mem_wstrb[0]),
            .wr_hp   (w_sel[gi] && w_hp_strb),
            .mode_in (mem_wdata[MODE_LSB +: 2]),
            .hp_in   (w_hp_in[gi]),
            .led     (w_led[gi]),
            .mode    (w_mode[gi]),
            .hp      (w_hp[gi])
         );
      end
   endgenerate

   always_comb begin
      w_rd = 32'h0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (mem_addr == ADDR_BITS'(i)) begin
            w_rd = w_ctrl[i];
         end
      end
      if (mem_addr == ADDR_BITS'(STATUS_IDX)) begin
         w_rd = 32'(w_led);
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_pre   <= '0;
         r_ready <= 1'b0;
         r_rdata <= 32'h0;
      end else begin
         r_pre   <= w_tick ? '0 : r_pre + PRE_BITS'(1);
         r_ready <= w_req;
         r_rdata <= w_req ? w_rd : 32'h0;
      end
   end

   assign mem_ready = r_ready;
   assign mem_rdata = r_rdata;
   assign led       = w_led;

endmodule
